dec_scan_n: RTL

Parametrised registered binary-to-one-hot decoder, the next generation of the 2-to-4 decoder with enable.
- Two modes. DIRECT decodes the sel input. SCAN auto-sequences through all outputs, holding each for a programmable dwell time.
- Used as the row/digit-select strobe generator feeding multiplexed display and bus-select logic.
- Outputs are registered, glitch-free and polarity-selectable.

---
 rtl/dec_pkg.sv | 25 ++
 rtl/dec_scan_n_if.sv | 18 +
 rtl/dwell_cnt.sv | 35 +++
 rtl/dec_scan_n.sv | 80 ++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
package dec_pkg;

  localparam logic ModeDirect = 1'b0;
  localparam logic ModeScan   = 1'b1;

  // Widest select the onehot helper supports; callers size-cast the result down.
  localparam int unsigned MaxSelW = 8;
  localparam int unsigned MaxOutW = 1 << MaxSelW;

  typedef enum logic [1:0] {
    StIdle,
    StDirect,
    StScan
  } state_e;

  function automatic logic [MaxOutW-1:0] onehot(input logic [MaxSelW-1:0] sel,
                                                input logic act_low);
    logic [MaxOutW-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return act_low ? ~v : v;
  endfunction

endpackage

// File: rtl/dec_scan_n_if.sv
// Control and decoded-output bundle of the scanning decoder.
interface dec_scan_n_if #(
  parameter int unsigned SEL_W = 2
);
  localparam int unsigned OUT_W = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic             load;
  logic [OUT_W-1:0] a;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (output en, mode, sel, load, input a, idx, wrap);
  modport slave  (input en, mode, sel, load, output a, idx, wrap);

endinterface

// File: rtl/dwell_cnt.sv
// Modulo-DWELL counter with synchronous clear and terminal-count flag.
module dwell_cnt #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CntW'(DWELL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dec_scan_n.sv
// Registered binary-to-one-hot decoder with direct and auto-scan modes.
module dec_scan_n
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL   = 4,
  parameter bit          ACT_LOW = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  dec_scan_n_if.slave  bus
);

  localparam int unsigned OUT_W = 1 << SEL_W;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] a_q, a_d;
  logic             wrap_q, wrap_d;
  logic             cnt_clr, cnt_inc, cnt_tc;

  dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    cnt_clr = 1'b1;
    cnt_inc = 1'b0;
    if (!bus.en) begin
      state_d = StIdle;
    end else if (bus.mode == ModeDirect) begin
      state_d = StDirect;
      idx_d   = bus.sel;
    end else begin
      state_d = StScan;
      if (state_q != StScan) begin
        idx_d = bus.load ? bus.sel : '0;
      end else if (bus.load) begin
        // Load wins over a coincident advance and never flags a wrap.
        idx_d = bus.sel;
      end else begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b1;
        if (cnt_tc) begin
          idx_d  = idx_q + SEL_W'(1);
          wrap_d = (idx_q == SEL_W'(OUT_W - 1));
        end
      end
    end
    a_d = (state_d == StIdle) ? {OUT_W{ACT_LOW}} : OUT_W'(onehot(MaxSelW'(idx_d), ACT_LOW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= {OUT_W{ACT_LOW}};
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.a    = a_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule
